// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the CLA nibble sequencer.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_t;

  // Nibble index width; a single-nibble build still needs a 1-bit index.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Feeds wide operands through an external registered 4-bit CLA one nibble at a time.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVERFLOW_FLAG_EN.
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*NIBBLES-1:0]  a,
  input  logic [4*NIBBLES-1:0]  b,
  input  logic                  c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*NIBBLES-1:0]  sum,
  output logic                  c_out,
  output logic [3:0]            cla_x,
  output logic [3:0]            cla_y,
  output logic                  cla_cin,
  input  logic [3:0]            cla_z,
  input  logic                  cla_cout
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
  ,
  output logic                  ovf
`endif
);

  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  seq_state_t state, nxt;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_reg, b_reg, sum_reg;
  logic [IW-1:0] idx;
  logic          carry;
  logic          c_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (idx == LAST) ? DONE : ISSUE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // rst_n gate keeps in_ready low while reset is held even though state is already IDLE.
  always_comb begin
    in_ready  = (state == IDLE) && rst_n;
    out_valid = (state == DONE);
    cla_x     = '0;
    cla_y     = '0;
    cla_cin   = 1'b0;
    if (state == ISSUE) begin
      cla_x   = a_reg[idx];
      cla_y   = b_reg[idx];
      cla_cin = carry;
    end
  end

  assign sum   = sum_reg;
  assign c_out = c_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      c_out_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= b;
          carry <= c_in;
          idx   <= '0;
        end
        // CLA outputs now hold the nibble issued in the previous cycle.
        WAIT: begin
          sum_reg[idx] <= cla_z;
          carry        <= cla_cout;
          if (idx == LAST) c_out_reg <= cla_cout;
          else             idx       <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_reg <= 1'b0;
    else if (state == WAIT && idx == LAST)
      ovf_reg <= (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3]) &&
                 (cla_z[3] != a_reg[NIBBLES-1][3]);
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench: sequencer instances (4 and 1 nibbles) each paired with a registered 4-bit adder.
module tb_cla_nibble_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // NIBBLES=4 instance
  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, c_in4 = 1'b0, c_out4;
  logic [15:0] a4 = '0, b4 = '0, sum4;
  logic [3:0]  x4, y4, z4;
  logic        cin4, cout4;
  // NIBBLES=1 instance
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, c_in1 = 1'b0, c_out1;
  logic [3:0]  a1 = '0, b1 = '0, sum1;
  logic [3:0]  x1, y1, z1;
  logic        cin1, cout1;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
  logic        ovf4, ovf1;
`endif

  cla_nibble_sequencer #(.NIBBLES(4)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c_in(c_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .c_out(c_out4), .cla_x(x4), .cla_y(y4), .cla_cin(cin4),
    .cla_z(z4), .cla_cout(cout4)
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    , .ovf(ovf4)
`endif
  );

  cla_nibble_sequencer #(.NIBBLES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1), .cla_x(x1), .cla_y(y1), .cla_cin(cin1),
    .cla_z(z1), .cla_cout(cout1)
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    , .ovf(ovf1)
`endif
  );

  // Registered 4-bit CLA stage stand-ins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cout4, z4} <= '0;
      {cout1, z1} <= '0;
    end else begin
      {cout4, z4} <= 5'(x4) + 5'(y4) + 5'(cin4);
      {cout1, z1} <= 5'(x1) + 5'(y1) + 5'(cin1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while d4 is IDLE; returns at the first negedge with out_valid high.
  task automatic run_op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] es, input logic eco, input logic eovf);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1; a4 = a; b4 = b; c_in4 = ci;
    @(negedge clk);
    in_valid4 = 1'b0; a4 = 16'hDEAD; b4 = 16'hBEEF; c_in4 = ~ci;
    lat = 1;
    check({tag, "_issue_x"}, 32'(x4), 32'(a[3:0]));
    check({tag, "_issue_y"}, 32'(y4), 32'(b[3:0]));
    check({tag, "_issue_cin"}, 32'(cin4), 32'(ci));
    while (out_valid4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) check({tag, "_wait_x"}, 32'(x4), 32'd0);
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_sum"}, 32'(sum4), 32'(es));
    check({tag, "_c_out"}, 32'(c_out4), 32'(eco));
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, 32'(ovf4), 32'(eovf));
`else
    if (eovf === 1'bx) $display("note: unexpected x");
`endif
  endtask

  task automatic release4(input string tag);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready4), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid4), 32'd0);
  endtask

  initial begin
    logic [15:0] held_sum;
    logic        held_co;
    logic        stable;
    int          lat;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready4), 32'd0);
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_sum", 32'(sum4), 32'd0);
    check("rst_c_out", 32'(c_out4), 32'd0);
    check("rst_cla_x", 32'(x4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: plain add
    run_op4("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    release4("t1");
    // 2: carry ripples through every nibble
    run_op4("t2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    release4("t2");
    // 3: signed overflow
    run_op4("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    release4("t3");

    // 4: backpressure then back-to-back
    run_op4("t4a", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    held_sum = sum4; held_co = c_out4; stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sum4 !== 16'h0000 || c_out4 !== 1'b1 || out_valid4 !== 1'b1 ||
          in_ready4 !== 1'b0 || x4 !== 4'h0 || y4 !== 4'h0) stable = 1'b0;
    end
    check("t4_hold_stable", 32'(stable), 32'd1);
    check("t4_hold_in_ready", 32'(in_ready4), 32'd0);
    check("t4_hold_sum", 32'(sum4), 32'(held_sum));
    check("t4_hold_c_out", 32'(c_out4), 32'(held_co));
    release4("t4");
    run_op4("t4b", 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0);
    release4("t4b");

    // 5: reset during third WAIT (cycle 6 after accept)
    check("t5_in_ready", 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1; a4 = 16'hF0F0; b4 = 16'hF0F0; c_in4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_pre_state", 32'(d4.state), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid4), 32'd0);
    check("t5_rst_state", 32'(d4.state), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready4), 32'd0);
    check("t5_rst_sum", 32'(sum4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op4("t5", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    release4("t5");

    // 6: single-nibble build
    check("t6_in_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1; a1 = 4'hF; b1 = 4'h1; c_in1 = 1'b0;
    @(negedge clk);
    in_valid1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    lat = 1;
    while (out_valid1 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t6_latency", 32'(lat), 32'd3);
    check("t6_sum", 32'(sum1), 32'h0);
    check("t6_c_out", 32'(c_out1), 32'd1);
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    check("t6_ovf", 32'(ovf1), 32'd0);
`endif
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("t6_idle", 32'(in_ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
- Upstream/downstream companion to the registered 4-bit CLA stage.
- Accepts wide operands over a valid/ready handshake and feeds them to the CLA one nibble per step, least-significant first.
- Chains the registered carry-out back into the next nibble's carry-in, reassembles the full-width sum, and presents it on a valid/ready output.
- The CLA is instantiated outside this block and connects through the cla_* ports.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 1..16).

Ports:
- clk  input  1  rising-edge clock, shared with the CLA stage
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, c_in are valid
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- c_in  input  1  carry into nibble 0
- out_valid  output  1  sum and c_out are valid
- out_ready  input  1  consumer accepts the result
- sum  output  W  assembled result
- c_out  output  1  carry out of the top nibble
- cla_x  output  4  nibble of A to the CLA
- cla_y  output  4  nibble of B to the CLA
- cla_cin  output  1  carry-in to the CLA
- cla_z  input  4  CLA registered sum; valid one cycle after issue
- cla_cout  input  1  CLA registered carry-out; valid one cycle after issue

Behaviour:
- Reset is asynchronous and active-low (rst_n), on a single clock clk. While rst_n=0:
  - state=IDLE, idx=0, carry=0;
  - a_reg, b_reg, sum_reg, c_out reg all 0;
  - in_ready=0 during reset and 1 in the first cycle after release;
  - out_valid=0.
- States:
  - IDLE: in_ready=1. On in_valid: latch a, b; set carry=c_in, idx=0; go to ISSUE.
  - ISSUE: cla_x = a_reg[4*idx+:4], cla_y = b_reg[4*idx+:4], cla_cin = carry; go to WAIT.
  - WAIT: CLA outputs now reflect the issued nibble. At the edge: sum_reg[4*idx+:4] <= cla_z; carry <= cla_cout.
    - If idx == NIBBLES-1: c_out <= cla_cout and go to DONE.
    - Otherwise idx++ and go to ISSUE.
  - DONE: out_valid=1; sum and c_out driven from registers and held stable. On out_ready, go to IDLE.
- cla_x, cla_y and cla_cin are 0 in every state except ISSUE. They are combinational from registers only, with no input-to-output combinational path.
- in_ready is 1 only in IDLE. There is no accept in DONE, even when out_ready=1 in the same cycle; the next accept happens in IDLE one cycle later.
- Latency: if the accept edge ends cycle 0, out_valid first rises in cycle 2*NIBBLES+1 (cycle 9 for NIBBLES=4). Throughput is one operation per 2*NIBBLES+2 cycles with out_ready held high.
- Arithmetic is unsigned modulo 2^W; carry out of the top nibble appears only on c_out. There are no wrap or idx overflow cases because idx never exceeds NIBBLES-1.
- Backpressure: with out_ready=0 the block stays in DONE indefinitely with outputs frozen.
- Inputs a, b and c_in are ignored outside the IDLE accept cycle.
- Reset mid-operation (any state) aborts the operation immediately:
  - outputs return to reset values asynchronously;
  - no partial result is ever presented;
  - CLA stage contents are ignored because WAIT is never re-entered without a preceding ISSUE.

Optional Feature:
- Macro: CLA_SEQ_OVERFLOW_FLAG_EN.
- Defined: adds output port ovf (1 bit), a registered signed two's-complement overflow flag.
  - Set in the final WAIT edge to (a_reg[W-1] == b_reg[W-1]) && (cla_z[3] != a_reg[W-1]).
  - Valid with out_valid and held in DONE; reset value 0.
- Undefined: no ovf port and no extra logic.

Decomposition:
- Package cla_seq_pkg holds:
  - localparam NIBBLE_W = 4;
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_t;
  - function for the index width, $clog2(NIBBLES) with a minimum of 1.
- No sub-module is needed; the nibble select/insert is an indexed part-select inside the FSM.
- The bench instantiates the existing CLA stage alongside the block.

Test Plan:
1. Reset then a=16'h1234, b=16'h4321, c_in=0 -> sum=16'h5555, c_out=0, out_valid rises exactly 9 cycles after the accept cycle.
2. a=16'hFFFF, b=16'h0000, c_in=1 -> carry ripples through all nibbles: sum=16'h0000, c_out=1. With the macro defined, ovf=0.
3. a=16'h7FFF, b=16'h0001, c_in=0 -> sum=16'h8000, c_out=0. With the macro defined, ovf=1. Without it, no ovf port exists.
4. Backpressure:
   - hold out_ready=0 for 20 cycles after out_valid -> sum and c_out are stable, in_ready=0, cla_x/cla_y=0;
   - assert out_ready -> IDLE next cycle, and a back-to-back second operation produces the correct result.
5. Deassert rst_n during the third WAIT of an operation -> out_valid=0 and state IDLE immediately. After release, a=16'h00FF, b=16'h0001 -> sum=16'h0100 with no residue from the aborted operation.
6. NIBBLES=1, a=4'hF, b=4'h1 -> sum=4'h0, c_out=1, latency 3 cycles.
